axi_write_arbiter: RTL and testbench

Write-path arbiter sharing one AXI write master port (AW, W, B) among NB_REQ requesters. The block sits in front of an interconnect manager port or a multicut slice chain. It round-robin arbitrates AW, keeps W beats in AW grant order through a grant-order FIFO, and routes B responses back using index bits it prepends to the ID. Read channels are out of scope.

---
 rtl/axi_write_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_axi_write_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_arbiter.sv
// Write-path arbiter: round-robin AW grant with a lock on pending handshakes,
// W beats forwarded in AW grant order via a small index FIFO, and B responses
// routed back using requester index bits prepended to the outgoing ID.
module axi_write_arbiter #(
  parameter int NB_REQ            = 4,
  parameter int AXI_ADDR_WIDTH    = 32,
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int AXI_ID_WIDTH      = 4,
  parameter int MAX_W_OUTSTANDING = 4,
  localparam int IDX_W      = $clog2(NB_REQ),
  localparam int AXI_ID_OUT = AXI_ID_WIDTH + IDX_W,
  localparam int STRB_W     = AXI_DATA_WIDTH / 8
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NB_REQ-1:0]                           s_aw_valid,
  output logic [NB_REQ-1:0]                           s_aw_ready,
  input  logic [NB_REQ-1:0][AXI_ID_WIDTH-1:0]         s_aw_id,
  input  logic [NB_REQ-1:0][AXI_ADDR_WIDTH-1:0]       s_aw_addr,
  input  logic [NB_REQ-1:0][7:0]                      s_aw_len,
  input  logic [NB_REQ-1:0]                           s_w_valid,
  output logic [NB_REQ-1:0]                           s_w_ready,
  input  logic [NB_REQ-1:0][AXI_DATA_WIDTH-1:0]       s_w_data,
  input  logic [NB_REQ-1:0][STRB_W-1:0]               s_w_strb,
  input  logic [NB_REQ-1:0]                           s_w_last,
  output logic [NB_REQ-1:0]                           s_b_valid,
  input  logic [NB_REQ-1:0]                           s_b_ready,
  output logic [NB_REQ-1:0][AXI_ID_WIDTH-1:0]         s_b_id,
  output logic [NB_REQ-1:0][1:0]                      s_b_resp,
  output logic                                        m_aw_valid,
  input  logic                                        m_aw_ready,
  output logic [AXI_ID_OUT-1:0]                       m_aw_id,
  output logic [AXI_ADDR_WIDTH-1:0]                   m_aw_addr,
  output logic [7:0]                                  m_aw_len,
  output logic                                        m_w_valid,
  input  logic                                        m_w_ready,
  output logic [AXI_DATA_WIDTH-1:0]                   m_w_data,
  output logic [STRB_W-1:0]                           m_w_strb,
  output logic                                        m_w_last,
  input  logic                                        m_b_valid,
  output logic                                        m_b_ready,
  input  logic [AXI_ID_OUT-1:0]                       m_b_id,
  input  logic [1:0]                                  m_b_resp,
  output logic                                        err_o
);

  localparam int PTR_W = (MAX_W_OUTSTANDING > 1) ? $clog2(MAX_W_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_W_OUTSTANDING + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, lock_idx_q, winner, grant_idx, cand;
  logic              any_valid, aw_hs, push, pop, fifo_full, fifo_empty, b_drop;
  int                j;
  logic [IDX_W-1:0]  fifo_mem [MAX_W_OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [IDX_W-1:0]  head, b_idx;
  logic [IDX_W:0]    b_idx_ext;

  function automatic logic [IDX_W-1:0] next_req(input logic [IDX_W-1:0] v);
    if (int'(v) == NB_REQ - 1) return '0;
    else return v + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (int'(p) == MAX_W_OUTSTANDING - 1) return '0;
    else return p + 1'b1;
  endfunction

  assign fifo_full  = (count_q == CNT_W'(MAX_W_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_mem[rd_ptr_q];
  assign grant_idx  = (state_q == LOCKED) ? lock_idx_q : winner;
  assign aw_hs      = m_aw_valid && m_aw_ready;
  assign push       = aw_hs;
  assign pop        = m_w_valid && m_w_ready && m_w_last;

  // Round-robin pick: descending scan so the lowest offset from rr_ptr wins.
  always_comb begin
    winner    = rr_ptr_q;
    any_valid = 1'b0;
    j         = 0;
    cand      = '0;
    for (int i = NB_REQ - 1; i >= 0; i--) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NB_REQ) j = j - NB_REQ;
      cand = IDX_W'(j);
      if (s_aw_valid[cand]) begin
        winner    = cand;
        any_valid = 1'b1;
      end
    end
  end

  // AW FSM next state and AW mux; the grant is frozen while LOCKED.
  always_comb begin
    state_d    = state_q;
    m_aw_valid = 1'b0;
    s_aw_ready = '0;
    case (state_q)
      IDLE:    m_aw_valid = any_valid && !fifo_full;
      LOCKED:  m_aw_valid = s_aw_valid[lock_idx_q];
      default: m_aw_valid = 1'b0;
    endcase
    if (rst) m_aw_valid = 1'b0;
    if (state_q == IDLE && m_aw_valid && !m_aw_ready) state_d = LOCKED;
    if (state_q == LOCKED && m_aw_valid && m_aw_ready) state_d = IDLE;
    s_aw_ready[grant_idx] = m_aw_valid && m_aw_ready;
    m_aw_id   = {grant_idx, s_aw_id[grant_idx]};
    m_aw_addr = s_aw_addr[grant_idx];
    m_aw_len  = s_aw_len[grant_idx];
  end

  // AW FSM state, lock index and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && m_aw_valid && !m_aw_ready) lock_idx_q <= winner;
      if (aw_hs) rr_ptr_q <= next_req(grant_idx);
    end
  end

  // Grant-order FIFO storage; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= grant_idx;
  end

  // Grant-order FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // W mux follows the FIFO head; nothing is forwarded while it is empty.
  always_comb begin
    m_w_valid = 1'b0;
    s_w_ready = '0;
    m_w_data  = s_w_data[head];
    m_w_strb  = s_w_strb[head];
    m_w_last  = s_w_last[head];
    if (!fifo_empty && !rst) begin
      m_w_valid       = s_w_valid[head];
      s_w_ready[head] = m_w_ready;
    end
  end

  // B demux on the prepended index; out-of-range beats are swallowed.
  always_comb begin
    b_idx     = m_b_id[AXI_ID_OUT-1:AXI_ID_WIDTH];
    b_idx_ext = {1'b0, b_idx};
    s_b_valid = '0;
    m_b_ready = 1'b0;
    b_drop    = 1'b0;
    for (int i = 0; i < NB_REQ; i++) begin
      s_b_id[i]   = m_b_id[AXI_ID_WIDTH-1:0];
      s_b_resp[i] = m_b_resp;
    end
    if (!rst) begin
      if (b_idx_ext >= (IDX_W+1)'(NB_REQ)) begin
        m_b_ready = 1'b1;
        b_drop    = m_b_valid;
      end else begin
        s_b_valid[b_idx] = m_b_valid;
        m_b_ready        = s_b_ready[b_idx];
      end
    end
  end

  // Sticky error flag for dropped B beats.
  always_ff @(posedge clk) begin
    if (rst)         err_o <= 1'b0;
    else if (b_drop) err_o <= 1'b1;
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Scoreboard bench for axi_write_arbiter: stimulus pushes expected AW/W/B
// transfers into queues, monitors pop and compare on each DUT handshake.
module tb_axi_write_arbiter;

  localparam int          ID_BASE   = 10;
  localparam logic [31:0] ADDR_BASE = 32'h1000_0000;
  localparam logic [31:0] D_BASE    = 32'hD000_0000;
  localparam logic [31:0] WB        = 32'hB000_0000;

  typedef struct packed { logic [5:0] id; logic [31:0] addr; logic [7:0] len; } aw_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } w_t;
  typedef struct packed { logic [1:0] port; logic [3:0] id; logic [1:0] resp; } b_t;

  logic clk = 1'b0;
  logic rst;
  logic [3:0]       s_aw_valid, s_aw_ready;
  logic [3:0][3:0]  s_aw_id;
  logic [3:0][31:0] s_aw_addr;
  logic [3:0][7:0]  s_aw_len;
  logic [3:0]       s_w_valid, s_w_ready, s_w_last;
  logic [3:0][31:0] s_w_data;
  logic [3:0][3:0]  s_w_strb;
  logic [3:0]       s_b_valid, s_b_ready;
  logic [3:0][3:0]  s_b_id;
  logic [3:0][1:0]  s_b_resp;
  logic             m_aw_valid, m_aw_ready;
  logic [5:0]       m_aw_id;
  logic [31:0]      m_aw_addr;
  logic [7:0]       m_aw_len;
  logic             m_w_valid, m_w_ready, m_w_last;
  logic [31:0]      m_w_data;
  logic [3:0]       m_w_strb;
  logic             m_b_valid, m_b_ready;
  logic [5:0]       m_b_id;
  logic [1:0]       m_b_resp;
  logic             err_o;

  logic [2:0]       s_aw_valid3, s_aw_ready3, s_w_valid3, s_w_ready3, s_w_last3;
  logic [2:0][3:0]  s_aw_id3, s_w_strb3, s_b_id3;
  logic [2:0][31:0] s_aw_addr3, s_w_data3;
  logic [2:0][7:0]  s_aw_len3;
  logic [2:0]       s_b_valid3, s_b_ready3;
  logic [2:0][1:0]  s_b_resp3;
  logic             m_aw_valid3, m_aw_ready3, m_w_valid3, m_w_ready3, m_w_last3;
  logic [5:0]       m_aw_id3, m_b_id3;
  logic [31:0]      m_aw_addr3, m_w_data3;
  logic [7:0]       m_aw_len3;
  logic [3:0]       m_w_strb3;
  logic             m_b_valid3, m_b_ready3, err3;
  logic [1:0]       m_b_resp3;

  int  n_cmp = 0;
  int  n_bad = 0;
  aw_t aw_q[$];
  w_t  w_q[$];
  b_t  b_q[$];
  aw_t e_aw;
  w_t  e_w;
  b_t  e_b;

  always #5 clk = ~clk;

  axi_write_arbiter dut (
    .clk(clk), .rst(rst),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_id(s_aw_id),
    .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data),
    .s_w_strb(s_w_strb), .s_w_last(s_w_last),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_id(m_aw_id),
    .m_aw_addr(m_aw_addr), .m_aw_len(m_aw_len),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data),
    .m_w_strb(m_w_strb), .m_w_last(m_w_last),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp),
    .err_o(err_o)
  );

  axi_write_arbiter #(.NB_REQ(3)) dut3 (
    .clk(clk), .rst(rst),
    .s_aw_valid(s_aw_valid3), .s_aw_ready(s_aw_ready3), .s_aw_id(s_aw_id3),
    .s_aw_addr(s_aw_addr3), .s_aw_len(s_aw_len3),
    .s_w_valid(s_w_valid3), .s_w_ready(s_w_ready3), .s_w_data(s_w_data3),
    .s_w_strb(s_w_strb3), .s_w_last(s_w_last3),
    .s_b_valid(s_b_valid3), .s_b_ready(s_b_ready3), .s_b_id(s_b_id3), .s_b_resp(s_b_resp3),
    .m_aw_valid(m_aw_valid3), .m_aw_ready(m_aw_ready3), .m_aw_id(m_aw_id3),
    .m_aw_addr(m_aw_addr3), .m_aw_len(m_aw_len3),
    .m_w_valid(m_w_valid3), .m_w_ready(m_w_ready3), .m_w_data(m_w_data3),
    .m_w_strb(m_w_strb3), .m_w_last(m_w_last3),
    .m_b_valid(m_b_valid3), .m_b_ready(m_b_ready3), .m_b_id(m_b_id3), .m_b_resp(m_b_resp3),
    .err_o(err3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic aw_t mk_aw(input int r, input int len);
    aw_t a;
    a.id   = {2'(r), 4'(ID_BASE + r)};
    a.addr = ADDR_BASE + 32'(r * 256);
    a.len  = 8'(len);
    return a;
  endfunction

  task automatic exp_aw(input int r, input int len);
    aw_q.push_back(mk_aw(r, len));
  endtask

  task automatic exp_w(input int r, input logic [31:0] data, input logic last);
    w_t w;
    w.data = data;
    w.strb = 4'(15 - r);
    w.last = last;
    w_q.push_back(w);
  endtask

  // AW monitor
  always @(negedge clk) begin
    if (!rst && m_aw_valid && m_aw_ready) begin
      if (aw_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL aw_extra: got id %0h addr %0h, expected no handshake", m_aw_id, m_aw_addr);
      end else begin
        e_aw = aw_q.pop_front();
        chk("aw_id", 64'(m_aw_id), 64'(e_aw.id));
        chk("aw_addr", 64'(m_aw_addr), 64'(e_aw.addr));
        chk("aw_len", 64'(m_aw_len), 64'(e_aw.len));
      end
    end
  end

  // W monitor
  always @(negedge clk) begin
    if (!rst && m_w_valid && m_w_ready) begin
      if (w_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL w_extra: got data %0h, expected no beat", m_w_data);
      end else begin
        e_w = w_q.pop_front();
        chk("w_data", 64'(m_w_data), 64'(e_w.data));
        chk("w_strb", 64'(m_w_strb), 64'(e_w.strb));
        chk("w_last", 64'(m_w_last), 64'(e_w.last));
      end
    end
  end

  // B monitor
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst && s_b_valid[i] && s_b_ready[i]) begin
        if (b_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_extra: got port %0d id %0h, expected no beat", i, s_b_id[i]);
        end else begin
          e_b = b_q.pop_front();
          chk("b_port", 64'(i), 64'(e_b.port));
          chk("b_id", 64'(s_b_id[i]), 64'(e_b.id));
          chk("b_resp", 64'(s_b_resp[i]), 64'(e_b.resp));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    s_aw_valid = '1; m_aw_ready = 1'b1; m_w_ready = 1'b1;
    s_w_valid = '1; s_w_last = '1;
    m_b_valid = 1'b0; m_b_id = '0; m_b_resp = '0; s_b_ready = '1;
    for (int i = 0; i < 4; i++) begin
      s_aw_id[i]   = 4'(ID_BASE + i);
      s_aw_addr[i] = ADDR_BASE + 32'(i * 256);
      s_aw_len[i]  = 8'd0;
      s_w_data[i]  = D_BASE + 32'(i);
      s_w_strb[i]  = 4'(15 - i);
    end
    s_aw_valid3 = '0; s_aw_id3 = '0; s_aw_addr3 = '0; s_aw_len3 = '0;
    s_w_valid3 = '0; s_w_data3 = '0; s_w_strb3 = '0; s_w_last3 = '0;
    s_b_ready3 = '1; m_aw_ready3 = 1'b1; m_w_ready3 = 1'b1;
    m_b_valid3 = 1'b0; m_b_id3 = '0; m_b_resp3 = '0;

    // reset with every requester valid
    repeat (3) begin
      @(negedge clk);
      chk("rst_outs", 64'({m_aw_valid, m_w_valid, m_b_ready, s_aw_ready, s_w_ready, s_b_valid, err_o, err3}), 64'(0));
    end
    step();
    // fairness 0,1,2,3,0 back to back
    exp_aw(0, 0); exp_aw(1, 0); exp_aw(2, 0); exp_aw(3, 0); exp_aw(0, 0);
    exp_w(0, D_BASE, 1'b1); exp_w(1, D_BASE + 1, 1'b1); exp_w(2, D_BASE + 2, 1'b1);
    exp_w(3, D_BASE + 3, 1'b1); exp_w(0, D_BASE, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("first_idx", 64'(m_aw_id[5:4]), 64'(0));
    repeat (5) step();
    s_aw_valid = '0;
    chk("fair_pending", 64'(aw_q.size()), 64'(0));
    repeat (3) step();

    // move rr_ptr to 2
    exp_aw(1, 0); exp_w(1, D_BASE + 1, 1'b1);
    s_aw_valid = 4'b0010;
    step();
    s_aw_valid = '0;
    repeat (2) step();

    // backpressure lock on requester 2
    exp_aw(2, 0); exp_aw(3, 0);
    exp_w(2, D_BASE + 2, 1'b1); exp_w(3, D_BASE + 3, 1'b1);
    m_aw_ready = 1'b0;
    s_aw_valid = 4'b1100;
    repeat (5) begin
      @(negedge clk);
      chk("lock_hold", 64'({m_aw_valid, s_aw_ready, m_aw_addr}), 64'({1'b1, 4'b0000, ADDR_BASE + 32'h200}));
      step();
    end
    m_aw_ready = 1'b1;
    step();
    s_aw_valid = 4'b1000;
    step();
    s_aw_valid = '0;
    chk("lock_pending", 64'(aw_q.size()), 64'(0));
    repeat (3) step();

    // W ordering: 1 (4 beats) then 0 (1 beat), 0 presents early
    exp_aw(1, 3); exp_aw(0, 0);
    for (int k = 0; k < 4; k++) exp_w(1, WB + 32'(k), k == 3);
    exp_w(0, D_BASE, 1'b1);
    s_aw_len[1] = 8'd3;
    s_aw_valid = 4'b0010;
    s_w_data[1] = WB; s_w_last[1] = 1'b0;
    step();
    s_aw_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      s_w_data[1] = WB + 32'(k);
      s_w_last[1] = (k == 3);
      if (k == 1) s_aw_valid = '0;
      @(negedge clk);
      chk("w_hold0", 64'(s_w_ready[0]), 64'(0));
      step();
    end
    s_w_valid[1] = 1'b0; s_w_data[1] = D_BASE + 1; s_w_last[1] = 1'b1; s_aw_len[1] = 8'd0;
    @(negedge clk);
    chk("w_ready0", 64'(s_w_ready), 64'(4'b0001));
    step();
    s_w_valid[1] = 1'b1;
    repeat (2) step();

    // FIFO full blocks the fifth AW until a last-beat pop
    exp_aw(1, 0); exp_aw(2, 0); exp_aw(3, 0); exp_aw(0, 0); exp_aw(1, 0);
    exp_w(1, D_BASE + 1, 1'b1); exp_w(2, D_BASE + 2, 1'b1); exp_w(3, D_BASE + 3, 1'b1);
    exp_w(0, D_BASE, 1'b1); exp_w(1, D_BASE + 1, 1'b1);
    m_w_ready = 1'b0;
    s_aw_valid = '1;
    repeat (4) step();
    @(negedge clk);
    chk("full_block", 64'({m_aw_valid, s_aw_ready}), 64'(0));
    step();
    @(negedge clk);
    chk("full_block2", 64'({m_aw_valid, s_aw_ready}), 64'(0));
    step();
    m_w_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_cycle", 64'({m_aw_valid, s_aw_ready}), 64'(0));
    step();
    @(negedge clk);
    chk("full_release", 64'({m_aw_valid, s_aw_ready}), 64'({1'b1, 4'b0010}));
    step();
    s_aw_valid = '0;
    repeat (6) step();

    // B routing
    b_q.push_back('{port: 2'd3, id: 4'h5, resp: 2'd2});
    m_b_valid = 1'b1; m_b_id = {2'd3, 4'h5}; m_b_resp = 2'd2;
    @(negedge clk);
    chk("b_route3", 64'({s_b_valid, m_b_ready}), 64'({4'b1000, 1'b1}));
    step();
    s_b_ready[3] = 1'b0;
    @(negedge clk);
    chk("b_backpressure", 64'({s_b_valid, m_b_ready}), 64'({4'b1000, 1'b0}));
    step();
    b_q.push_back('{port: 2'd0, id: 4'hA, resp: 2'd0});
    s_b_ready = '1; m_b_id = {2'd0, 4'hA}; m_b_resp = 2'd0;
    step();
    m_b_valid = 1'b0;

    // out-of-range B index with three requesters
    m_b_valid3 = 1'b1; m_b_id3 = {2'd2, 4'h7};
    @(negedge clk);
    chk("b3_inrange", 64'({s_b_valid3, m_b_ready3}), 64'({3'b100, 1'b1}));
    step();
    m_b_id3 = {2'd3, 4'h7};
    @(negedge clk);
    chk("b3_drop", 64'({s_b_valid3, m_b_ready3, err3}), 64'({3'b000, 1'b1, 1'b0}));
    step();
    m_b_valid3 = 1'b0;
    @(negedge clk);
    chk("err3_set", 64'({err3, err_o}), 64'({1'b1, 1'b0}));
    repeat (3) step();
    @(negedge clk);
    chk("err3_sticky", 64'(err3), 64'(1));
    step();
    rst = 1'b1;
    s_aw_valid = '1;
    step();
    @(negedge clk);
    chk("err3_rst", 64'(err3), 64'(0));
    chk("rst_outs2", 64'({m_aw_valid, m_w_valid, m_b_ready, s_aw_ready, s_w_ready, s_b_valid}), 64'(0));
    step();
    s_aw_valid = '0;
    rst = 1'b0;
    step();

    chk("aw_q_empty", 64'(aw_q.size()), 64'(0));
    chk("w_q_empty", 64'(w_q.size()), 64'(0));
    chk("b_q_empty", 64'(b_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
